// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial LSB-first subtractor (diff = a - b), IDLE/RUN/DONE FSM.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             busy_q, busy_d, done_q, done_d, borrow_q, borrow_d;

  logic             bit_d, bit_br;
  logic [WIDTH-1:0] res_sh;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, a_msb_d, b_msb_q, b_msb_d, ovf_q, ovf_d;
`endif

  always_comb begin
    bit_d  = a_q[0] ^ b_q[0] ^ br_q;
    bit_br = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    // Result fills from the top so the LSB ends in bit 0 after WIDTH shifts.
    res_sh            = res_q >> 1;
    res_sh[WIDTH-1]   = bit_d;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          cnt_d   = '0;
          br_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_RUN;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_sh;
        br_d  = bit_br;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = S_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          diff_d   = res_sh;
          borrow_d = bit_br;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d    = (a_msb_q != b_msb_q) && (res_sh[WIDTH-1] != a_msb_q);
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - directed self-checking bench for serial_sub (WIDTH=8 and WIDTH=1).
// Define SERIAL_SUB_OVF_EN to also exercise the ovf output.
module tb_serial_sub;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, start1;
  logic [7:0] a8, b8, diff8;
  logic       a1, b1, diff1;
  logic       busy8, done8, borrow8, busy1, done1, borrow1;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf8, ovf1;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_sub #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one WIDTH=8 operation from IDLE and leaves the DUT back in IDLE.
  task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] exp_d, input logic exp_b);
    int n;
    a8 = av; b8 = bv; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n = 0;
    while (done8 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 8);
    chk({tag, "_diff"}, diff8, exp_d);
    chk({tag, "_borrow"}, borrow8, exp_b);
    tick();
  endtask

  task automatic op1(input string tag, input logic av, input logic bv,
                     input logic [1:0] exp_bd);
    a1 = av; b1 = bv; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk({tag, "_early_done"}, done1, 1'b0);
    tick();
    chk({tag, "_done"}, done1, 1'b1);
    chk({tag, "_bd"}, {borrow1, diff1}, exp_bd);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; a1 = 1'b0; b1 = 1'b0;
    tick(); tick();
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_diff", diff8, 8'h00);
    chk("rst_borrow", borrow8, 1'b0);
    #3 rst_n = 1'b1;
    tick();

    // 5 - 3 with cycle-exact busy/done observation
    a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("t53_busy_%0d", i), busy8, 1'b1);
      chk($sformatf("t53_done_%0d", i), done8, 1'b0);
      tick();
    end
    chk("t53_busy_end", busy8, 1'b0);
    chk("t53_done_S9", done8, 1'b1);
    chk("t53_diff", diff8, 8'h02);
    chk("t53_borrow", borrow8, 1'b0);
    tick();
    chk("t53_done_S10", done8, 1'b0);

    op8("t00_01", 8'h00, 8'h01, 8'hFF, 1'b1);
    op8("tFF_FF", 8'hFF, 8'hFF, 8'h00, 1'b0);
    op8("t80_01", 8'h80, 8'h01, 8'h7F, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    chk("t80_01_ovf", ovf8, 1'b1);
`endif
    op8("t10_01", 8'h10, 8'h01, 8'h0F, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    chk("t10_01_ovf", ovf8, 1'b0);
`endif

    // Start and operand changes during RUN must be ignored; diff holds during RUN
    a8 = 8'h0A; b8 = 8'h04; start8 = 1'b1;
    tick();
    a8 = 8'h01; b8 = 8'h02;
    tick(); tick();
    chk("ign_diff_hold", diff8, 8'h0F);
    start8 = 1'b0;
    for (int i = 0; i < 20 && done8 !== 1'b1; i++) tick();
    chk("ign_done", done8, 1'b1);
    chk("ign_diff", diff8, 8'h06);
    chk("ign_borrow", borrow8, 1'b0);
    tick();
    chk("ign_no_restart", busy8, 1'b0);

    // Asynchronous reset in the 4th RUN cycle
    a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    chk("abort_busy_pre", busy8, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy8, 1'b0);
    chk("abort_done", done8, 1'b0);
    chk("abort_diff", diff8, 8'h00);
`ifdef SERIAL_SUB_OVF_EN
    chk("abort_ovf", ovf8, 1'b0);
`endif
    #2 rst_n = 1'b1;
    tick();
    op8("t09_09", 8'h09, 8'h09, 8'h00, 1'b0);
    op8("t03_05", 8'h03, 8'h05, 8'hFE, 1'b1);

    op1("w1_00", 1'b0, 1'b0, 2'b00);
    op1("w1_01", 1'b0, 1'b1, 2'b11);
    op1("w1_10", 1'b1, 1'b0, 2'b01);
    op1("w1_11", 1'b1, 1'b1, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 1..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock; the block has one clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to load the operands; honoured only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  unsigned minuend; sampled on the start edge only.
REQ-006 SHALL have port b  input  WIDTH  unsigned subtrahend; sampled on the start edge only.
REQ-007 SHALL have port busy  output  1  high while in RUN.
REQ-008 SHALL have port done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port diff  output  WIDTH  registered result, a - b mod 2^WIDTH.
REQ-010 SHALL have port borrow  output  1  registered final borrow; 1 when a < b unsigned.
REQ-011 SHALL have port ovf  output  1  signed overflow flag; the port exists only when SERIAL_SUB_OVF_EN is defined.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-013 SHALL, in IDLE with start=1 at an edge, load a and b into shift registers, clear the internal borrow flop and the bit counter, and enter RUN.
REQ-014 SHALL, at each RUN edge, process one bit pair LSB-first: d = a0^b0^br; br' = (~a0&b0) | (~(a0^b0)&br).
REQ-015 SHALL, at each RUN edge, shift d into an internal result shift register and shift the operand registers right by one bit.
REQ-016 SHALL leave RUN after exactly WIDTH processing edges and enter DONE.
REQ-017 SHALL update diff and borrow (and ovf when compiled in) only on the RUN-to-DONE edge; they hold their value otherwise, including during the next RUN.
REQ-018 SHALL assert done for exactly one cycle, in DONE, and then return to IDLE on the next edge.
REQ-019 SHALL give done sampled high at edge S+WIDTH+1, where S is the start edge.
REQ-020 SHALL accept a new start at the first edge after done (IDLE), giving back-to-back throughput of one result per WIDTH+2 cycles.
REQ-021 SHALL ignore start while in RUN or DONE; operand changes in those states SHALL NOT affect the result.
REQ-022 SHALL behave at WIDTH=1 exactly as a half subtractor: diff = a^b, borrow = ~a&b, with the same latency rule.
REQ-023 SHALL drive busy and done from registers, with no combinational path from any input.

Reset
REQ-024 SHALL, when rst_n=0 at any time including mid-RUN, immediately force state=IDLE, busy=0, done=0, diff=0, borrow=0, ovf=0, and clear all internal registers.
REQ-025 SHALL discard an operation aborted by reset; the first start after rst_n deasserts SHALL behave normally.

Configuration
REQ-026 SHALL, with SERIAL_SUB_OVF_EN defined, capture the operand MSBs at start and set ovf = (a_msb != b_msb) && (diff_msb != a_msb), updated together with diff.
REQ-027 SHALL, without SERIAL_SUB_OVF_EN, have no ovf port and no associated logic; all other behaviour SHALL be identical.

Verification (WIDTH=8 unless stated)
REQ-028 SHALL cover: a=0x05, b=0x03, start at edge S -> diff=0x02, borrow=0, done high only at S+9, busy high for edges S+1..S+8.
REQ-029 SHALL cover: a=0x00, b=0x01 -> diff=0xFF, borrow=1; a=0xFF, b=0xFF -> diff=0x00, borrow=0.
REQ-030 SHALL cover, with SERIAL_SUB_OVF_EN defined: a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1; a=0x10, b=0x01 -> ovf=0.
REQ-031 SHALL cover: start with a=0x0A, b=0x04, then start=1 with a=0x01, b=0x02 during RUN -> diff=0x06, and the second request is ignored.
REQ-032 SHALL cover: rst_n pulsed low at the 4th RUN cycle -> busy=0, done=0, diff=0 without waiting for a clock edge; then a=0x09, b=0x09 -> diff=0x00, borrow=0.
REQ-033 SHALL cover: WIDTH=1 with all four {a,b} combinations -> {borrow,diff} = 00, 11, 01, 00 for ab = 00, 01, 10, 11, with done at S+2.
